cpu_clock_ctrl: RTL and testbench

Parametrised CPU clock-enable controller for the board top level. It replaces derived-clock generation with a single-clock-domain tick (`oCLK_EN`) that the processor core uses as a clock enable. It provides manual single-step, auto-slow and auto-fast modes from debounced push-buttons, a runtime divisor, and an optional tick budget that halts the core after N cycles.

---
 rtl/clock_ctrl_pkg.sv | 29 ++
 rtl/key_debounce.sv | 59 +++++
 rtl/cpu_clock_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clock_ctrl_pkg
//   Shared types and constants for the CPU clock-enable controller.
//   - MODE_* : encodings driven on the controller's mode output.
//   - state_t: controller FSM states.
//   - mode_code(): maps (state, fast flag) to the mode output encoding.
// -----------------------------------------------------------------------------
package clock_ctrl_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SLOW   = 2'b01;
  localparam logic [1:0] MODE_FAST   = 2'b11;

  typedef enum logic [1:0] {
    ST_MANUAL,
    ST_AUTO,
    ST_HALT
  } state_t;

  // Only AUTO reports a running mode; MANUAL and HALT both read as 00 so the
  // display never claims the core is free-running while it is stopped.
  function automatic logic [1:0] mode_code(input state_t st, input logic fast);
    if (st != ST_AUTO) begin
      return MODE_MANUAL;
    end
    return fast ? MODE_FAST : MODE_SLOW;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Conditions one active-low asynchronous push-button.
//   A 2-FF synchroniser feeds a stable-sample counter; the debounced level only
//   follows the synchronised input after DB_CYC consecutive samples that all
//   differ from the current level. A debounced 1->0 transition produces a
//   single-cycle press pulse; releases produce nothing.
//
//   Ports:
//     clk    in  1  sampling clock
//     rst_n  in  1  synchronous active-low reset (level returns to released)
//     key    in  1  raw active-low key, asynchronous to clk
//     press  out 1  one-cycle pulse on every accepted press
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DB_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  // Counter only needs to reach DB_CYC-1: the DB_CYC-th differing sample is
  // the one that flips the level.
  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] stable_cnt;

  // NOTE: non-blocking assignments make sync1 -> sync2 -> level a true pipeline;
  // blocking ones would collapse the stages into a single flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      level      <= 1'b1;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        // Any sample agreeing with the current level restarts the run.
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DB_CYC - 1)) begin
        level      <= sync2;
        stable_cnt <= '0;
        press      <= ~sync2;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clock_ctrl
//   Single-clock-domain clock-enable generator for the processor core.
//   Three debounced keys drive a MANUAL / AUTO / HALT state machine:
//     MANUAL : each step press issues one tick.
//     AUTO   : a divider issues one tick every P cycles, where
//              P = max(iDIV,1) in fast mode, or that value << SLOW_SHIFT in
//              slow mode. P is latched on AUTO entry, on every slow/fast press
//              and at every divider wrap, so an iDIV change mid-period never
//              shortens the running period.
//     HALT   : entered when the optional tick budget is exhausted; an
//              auto/manual press clears the tick count and returns to MANUAL.
//
//   Ports:
//     iCLK_50     in  1      sole clock, rising edge
//     iRST_n      in  1      synchronous active-low reset
//     iKEY        in  3      active-low keys: [2] step, [1] auto/manual,
//                            [0] slow/fast
//     iDIV        in  DIV_W  fast period in clock cycles (0 behaves as 1)
//     iBUDGET     in  TMR_W  tick budget
//     iBUDGET_EN  in  1      enables the budget halt
//     oCLK_EN     out 1      one-cycle tick to the core (registered)
//     oCLK        out 1      toggles on every tick, for display
//     oMODE       out 2      00 manual, 01 auto-slow, 11 auto-fast
//     oHALTED     out 1      budget exhausted
//     oTICKS      out TMR_W  ticks since reset or since the last halt clear
// -----------------------------------------------------------------------------
module cpu_clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int SLOW_SHIFT = 18,
  parameter int DB_CYC     = 500000,
  parameter int TMR_W      = 32
) (
  input  logic             iCLK_50,
  input  logic             iRST_n,
  input  logic [2:0]       iKEY,
  input  logic [DIV_W-1:0] iDIV,
  input  logic [TMR_W-1:0] iBUDGET,
  input  logic             iBUDGET_EN,
  output logic             oCLK_EN,
  output logic             oCLK,
  output logic [1:0]       oMODE,
  output logic             oHALTED,
  output logic [TMR_W-1:0] oTICKS
);

  // Wide enough to hold the slow period without overflow.
  localparam int CNT_W = DIV_W + SLOW_SHIFT;

  // ---------------------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------------------
  logic [2:0] press;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(
      .DB_CYC (DB_CYC)
    ) u_debounce (
      .clk   (iCLK_50),
      .rst_n (iRST_n),
      .key   (iKEY[k]),
      .press (press[k])
    );
  end

  logic step_press;
  logic am_press;
  logic sf_press;

  assign step_press = press[2];
  assign am_press   = press[1];
  assign sf_press   = press[0];

  // ---------------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic             fast;
  logic             fast_nxt;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_nxt;
  logic [DIV_W-1:0] div_eff;
  logic             wrap;
  logic             budget_hit;
  logic             halt_clear;
  logic             tick;

  // NOTE: every signal driven here gets a default on every path, so no latch
  // can be inferred even if a branch is added later.
  always_comb begin
    fast_nxt   = fast ^ sf_press;
    div_eff    = (iDIV == '0) ? DIV_W'(1) : iDIV;
    period_nxt = fast_nxt ? CNT_W'(div_eff)
                          : (CNT_W'(div_eff) << SLOW_SHIFT);

    wrap = (state == ST_AUTO) && (div_cnt == period - CNT_W'(1));

    // Budget is checked against the registered count, which already includes
    // the tick pulsing this cycle; a late enable with the count already past
    // the budget halts the same way, without issuing another tick.
    budget_hit = iBUDGET_EN && (iBUDGET != '0) && (oTICKS >= iBUDGET) &&
                 (state != ST_HALT);

    halt_clear = (state == ST_HALT) && am_press;

    tick = !budget_hit &&
           (((state == ST_MANUAL) && step_press) || wrap);

    state_nxt = state;
    if (budget_hit) begin
      // Halt wins over a simultaneous auto/manual press, which is dropped.
      state_nxt = ST_HALT;
    end else begin
      case (state)
        ST_MANUAL: if (am_press) state_nxt = ST_AUTO;
        ST_AUTO:   if (am_press) state_nxt = ST_MANUAL;
        ST_HALT:   if (am_press) state_nxt = ST_MANUAL;
        default:   state_nxt = ST_MANUAL;
      endcase
    end
  end

  always_ff @(posedge iCLK_50) begin
    if (!iRST_n) begin
      state   <= ST_MANUAL;
      fast    <= 1'b0;
      div_cnt <= '0;
      period  <= CNT_W'(1);
      oCLK_EN <= 1'b0;
      oCLK    <= 1'b0;
      oMODE   <= MODE_MANUAL;
      oHALTED <= 1'b0;
      oTICKS  <= '0;
    end else begin
      state   <= state_nxt;
      fast    <= fast_nxt;
      oCLK_EN <= tick;
      oHALTED <= (state_nxt == ST_HALT);
      oMODE   <= mode_code(state_nxt, fast_nxt);

      if (tick) begin
        oCLK <= ~oCLK;
      end

      if (halt_clear) begin
        oTICKS <= '0;
      end else if (tick) begin
        oTICKS <= oTICKS + TMR_W'(1);
      end

      // Divider: restart and relatch P on entry, on a slow/fast press and at
      // each wrap; the first tick then lands exactly P cycles after the state
      // register shows AUTO.
      if (state_nxt != ST_AUTO) begin
        div_cnt <= '0;
      end else if ((state != ST_AUTO) || sf_press || wrap) begin
        div_cnt <= '0;
        period  <= period_nxt;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_clock_ctrl
//   Self-checking bench for cpu_clock_ctrl with DB_CYC=4, DIV_W=8,
//   SLOW_SHIFT=2. Tick arrival cycles are predicted arithmetically from key
//   press times and periods, and compared with the ticks a monitor records.
// -----------------------------------------------------------------------------
module tb_cpu_clock_ctrl;

  localparam int DB = 4;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TW = 32;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [2:0]    key       = 3'b111;
  logic [DW-1:0] div       = 8'd5;
  logic [TW-1:0] budget    = '0;
  logic          budget_en = 1'b0;

  logic          clk_en;
  logic          clk_disp;
  logic [1:0]    mode;
  logic          halted;
  logic [TW-1:0] ticks;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int tick_q[$];
  int halt_cyc = -1;
  logic halted_d = 1'b0;
  bit model_fast = 1'b0;

  cpu_clock_ctrl #(
    .DIV_W      (DW),
    .SLOW_SHIFT (SS),
    .DB_CYC     (DB),
    .TMR_W      (TW)
  ) dut (
    .iCLK_50    (clk),
    .iRST_n     (rst_n),
    .iKEY       (key),
    .iDIV       (div),
    .iBUDGET    (budget),
    .iBUDGET_EN (budget_en),
    .oCLK_EN    (clk_en),
    .oCLK       (clk_disp),
    .oMODE      (mode),
    .oHALTED    (halted),
    .oTICKS     (ticks)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of every tick and of every halt rise, sampled mid-cycle.
  always @(negedge clk) begin
    if (clk_en === 1'b1) tick_q.push_back(cyc);
    if (halted === 1'b1 && halted_d !== 1'b1) halt_cyc <= cyc;
    halted_d <= halted;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // Period of AUTO mode from the divisor and speed, straight from the rules.
  function automatic int period_of(input int d, input bit f);
    int b;
    b = (d == 0) ? 1 : d;
    return f ? b : (b << SS);
  endfunction

  function automatic int tick_at(input int i);
    return (i >= 0 && i < tick_q.size()) ? tick_q[i] : -1;
  endfunction

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the masked keys low long enough to be accepted, then release and let
  // the release settle. pc is the cycle in which the keys first read low; the
  // press event is seen in pc+DB+2 and its effect appears in pc+DB+3.
  task automatic press_keys(input logic [2:0] mask, output int pc);
    @(posedge clk);
    #1;
    key = key & ~mask;
    pc  = cyc;
    step_cycles(DB + 4);
    key = 3'b111;
    step_cycles(DB + 4);
  endtask

  task automatic wait_ticks(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (tick_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step_cycles(1);
    end
    if (tick_q.size() >= n) ok = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step_cycles(2);
    rst_n = 1'b1;
    step_cycles(1);
    tick_q.delete();
    model_fast = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    step_cycles(3);
    n_cmp++;
    if (clk_en !== 1'b0) begin n_bad++; $display("FAIL reset_clk_en: got %b, required 0", clk_en); end
    n_cmp++;
    if (clk_disp !== 1'b0) begin n_bad++; $display("FAIL reset_clk: got %b, required 0", clk_disp); end
    n_cmp++;
    if (mode !== 2'b00) begin n_bad++; $display("FAIL reset_mode: got %b, required 00", mode); end
    n_cmp++;
    if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b, required 0", halted); end
    n_cmp++;
    if (ticks !== '0) begin n_bad++; $display("FAIL reset_ticks: got %0d, required 0", ticks); end
    rst_n = 1'b1;
    tick_q.delete();
    model_fast = 1'b0;
    step_cycles(10);
    n_cmp++;
    if (tick_q.size() != 0) begin n_bad++; $display("FAIL idle_ticks: got %0d, required 0", tick_q.size()); end
  endtask

  task automatic test_manual_step();
    int pc;
    int exp_q[$];
    tick_q.delete();
    for (int i = 0; i < 3; i++) begin
      step_cycles($urandom_range(0, 5));
      press_keys(3'b100, pc);
      exp_q.push_back(pc + DB + 3);
    end
    n_cmp++;
    if (tick_q.size() != 3) begin n_bad++; $display("FAIL manual_count: got %0d, required 3", tick_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tick_at(i) != exp_q[i]) begin n_bad++; $display("FAIL manual_tick%0d: got cycle %0d, required %0d", i, tick_at(i), exp_q[i]); end
    end
    n_cmp++;
    if (ticks !== TW'(3)) begin n_bad++; $display("FAIL manual_ticks: got %0d, required 3", ticks); end
    n_cmp++;
    if (clk_disp !== 1'b1) begin n_bad++; $display("FAIL manual_clk: got %b, required 1", clk_disp); end
    n_cmp++;
    if (mode !== 2'b00) begin n_bad++; $display("FAIL manual_mode: got %b, required 00", mode); end
  endtask

  task automatic test_bounce();
    int pc;
    int len;
    tick_q.delete();
    for (int i = 0; i < 10; i++) begin
      key[2] = ~key[2];
      step_cycles(2);
    end
    key = 3'b111;
    step_cycles(10);
    // Low runs one short of the acceptance count, then random shorter ones.
    for (int i = 0; i < 3; i++) begin
      len = (i == 0) ? DB - 1 : $urandom_range(1, DB - 1);
      key[2] = 1'b0;
      step_cycles(len);
      key[2] = 1'b1;
      step_cycles(DB + 4);
    end
    n_cmp++;
    if (tick_q.size() != 0) begin n_bad++; $display("FAIL bounce_ticks: got %0d, required 0", tick_q.size()); end
    n_cmp++;
    if (ticks !== TW'(3)) begin n_bad++; $display("FAIL bounce_count: got %0d, required 3", ticks); end
    // Exactly DB low samples is the shortest accepted press.
    @(posedge clk);
    #1;
    key[2] = 1'b0;
    pc = cyc;
    step_cycles(DB);
    key[2] = 1'b1;
    step_cycles(DB + 4);
    n_cmp++;
    if (tick_q.size() != 1 || tick_at(0) != pc + DB + 3) begin
      n_bad++;
      $display("FAIL min_press: got %0d ticks first at %0d, required 1 at %0d", tick_q.size(), tick_at(0), pc + DB + 3);
    end
  endtask

  task automatic test_auto();
    int pc;
    int e;
    int p;
    int n0;
    int last;
    bit ok;
    div = 8'd5;
    tick_q.delete();
    press_keys(3'b010, pc);
    e = pc + DB + 3;
    p = period_of(5, model_fast);
    n_cmp++;
    if (mode !== 2'b01) begin n_bad++; $display("FAIL auto_slow_mode: got %b, required 01", mode); end
    wait_ticks(3, 120, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL auto_slow_wait: got %0d ticks, required 3", tick_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tick_at(i) != e + p * (i + 1)) begin n_bad++; $display("FAIL auto_slow_tick%0d: got cycle %0d, required %0d", i, tick_at(i), e + p * (i + 1)); end
    end

    press_keys(3'b001, pc);
    model_fast = ~model_fast;
    p = period_of(5, model_fast);
    n_cmp++;
    if (mode !== 2'b11) begin n_bad++; $display("FAIL auto_fast_mode: got %b, required 11", mode); end
    tick_q.delete();
    wait_ticks(4, 60, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL auto_fast_wait: got %0d ticks, required 4", tick_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tick_at(i + 1) - tick_at(i) != p) begin n_bad++; $display("FAIL auto_fast_gap%0d: got %0d, required %0d", i, tick_at(i + 1) - tick_at(i), p); end
    end

    // Divisor 0: the running period finishes, then ticks come every cycle.
    @(posedge clk);
    #1;
    div = '0;
    @(negedge clk);
    #1;
    n0   = tick_q.size();
    last = tick_at(n0 - 1);
    wait_ticks(n0 + 6, 40, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL div0_wait: got %0d ticks, required %0d", tick_q.size(), n0 + 6); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (tick_at(n0 + k) != last + p + k) begin n_bad++; $display("FAIL div0_tick%0d: got cycle %0d, required %0d", k, tick_at(n0 + k), last + p + k); end
    end
  endtask

  task automatic test_reset_mid_run();
    int pn;
    int p;
    bit found;
    pn  = $urandom_range(3, 9);
    div = DW'(pn);
    p   = period_of(pn, model_fast);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step_cycles(1);
      if (clk_en === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL midrst_wait: got no tick, required one"); end
    // Assert reset in the cycle that would otherwise schedule the next tick.
    step_cycles(p - 1);
    rst_n = 1'b0;
    step_cycles(1);
    n_cmp++;
    if (clk_en !== 1'b0) begin n_bad++; $display("FAIL midrst_clk_en: got %b, required 0", clk_en); end
    n_cmp++;
    if (clk_disp !== 1'b0) begin n_bad++; $display("FAIL midrst_clk: got %b, required 0", clk_disp); end
    n_cmp++;
    if (mode !== 2'b00) begin n_bad++; $display("FAIL midrst_mode: got %b, required 00", mode); end
    n_cmp++;
    if (ticks !== '0) begin n_bad++; $display("FAIL midrst_ticks: got %0d, required 0", ticks); end
    step_cycles(1);
    rst_n = 1'b1;
    model_fast = 1'b0;
    step_cycles(1);
    tick_q.delete();
  endtask

  task automatic test_simultaneous();
    int pc;
    int e;
    int p;
    int d;
    bit ok;
    d   = $urandom_range(2, 6);
    div = DW'(d);
    tick_q.delete();
    press_keys(3'b011, pc);
    model_fast = ~model_fast;
    e = pc + DB + 3;
    p = period_of(d, model_fast);
    n_cmp++;
    if (mode !== 2'b11) begin n_bad++; $display("FAIL simul_mode: got %b, required 11", mode); end
    wait_ticks(3, 60, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL simul_wait: got %0d ticks, required 3", tick_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tick_at(i) != e + p * (i + 1)) begin n_bad++; $display("FAIL simul_tick%0d: got cycle %0d, required %0d", i, tick_at(i), e + p * (i + 1)); end
    end
  endtask

  task automatic test_budget();
    int pc;
    int e;
    int p;
    int d;
    apply_reset();
    d         = $urandom_range(1, 4);
    div       = DW'(d);
    budget    = TW'(7);
    budget_en = 1'b1;
    halt_cyc  = -1;
    press_keys(3'b001, pc);
    model_fast = ~model_fast;
    tick_q.delete();
    press_keys(3'b010, pc);
    e = pc + DB + 3;
    p = period_of(d, model_fast);
    for (int i = 0; i < 100 && halted !== 1'b1; i++) step_cycles(1);
    step_cycles(10);
    n_cmp++;
    if (tick_q.size() != 7) begin n_bad++; $display("FAIL budget_count: got %0d, required 7", tick_q.size()); end
    n_cmp++;
    if (tick_at(0) != e + p) begin n_bad++; $display("FAIL budget_first: got cycle %0d, required %0d", tick_at(0), e + p); end
    n_cmp++;
    if (tick_at(6) != e + 7 * p) begin n_bad++; $display("FAIL budget_last: got cycle %0d, required %0d", tick_at(6), e + 7 * p); end
    n_cmp++;
    if (halt_cyc != e + 7 * p + 1) begin n_bad++; $display("FAIL budget_halt_cyc: got %0d, required %0d", halt_cyc, e + 7 * p + 1); end
    n_cmp++;
    if (halted !== 1'b1) begin n_bad++; $display("FAIL budget_halted: got %b, required 1", halted); end
    n_cmp++;
    if (ticks !== TW'(7)) begin n_bad++; $display("FAIL budget_ticks: got %0d, required 7", ticks); end
    n_cmp++;
    if (mode !== 2'b00) begin n_bad++; $display("FAIL budget_mode: got %b, required 00", mode); end
    n_cmp++;
    if (clk_disp !== 1'b1) begin n_bad++; $display("FAIL budget_clk: got %b, required 1", clk_disp); end
    // Step is ignored while halted.
    press_keys(3'b100, pc);
    n_cmp++;
    if (tick_q.size() != 7) begin n_bad++; $display("FAIL halt_step: got %0d ticks, required 7", tick_q.size()); end
    press_keys(3'b010, pc);
    n_cmp++;
    if (ticks !== '0) begin n_bad++; $display("FAIL clear_ticks: got %0d, required 0", ticks); end
    n_cmp++;
    if (halted !== 1'b0) begin n_bad++; $display("FAIL clear_halted: got %b, required 0", halted); end
    n_cmp++;
    if (mode !== 2'b00) begin n_bad++; $display("FAIL clear_mode: got %b, required 00", mode); end
  endtask

  task automatic test_budget_late_enable();
    int pc;
    int n;
    budget_en = 1'b0;
    n = $urandom_range(2, 4);
    tick_q.delete();
    for (int i = 0; i < n; i++) press_keys(3'b100, pc);
    n_cmp++;
    if (ticks !== TW'(n)) begin n_bad++; $display("FAIL late_pre_ticks: got %0d, required %0d", ticks, n); end
    budget = TW'($urandom_range(1, n));
    @(posedge clk);
    #1;
    budget_en = 1'b1;
    step_cycles(1);
    n_cmp++;
    if (halted !== 1'b1) begin n_bad++; $display("FAIL late_halted: got %b, required 1", halted); end
    step_cycles(3);
    n_cmp++;
    if (ticks !== TW'(n) || tick_q.size() != n) begin n_bad++; $display("FAIL late_no_tick: got %0d ticks, required %0d", ticks, n); end
    budget_en = 1'b0;
    press_keys(3'b010, pc);
    n_cmp++;
    if (halted !== 1'b0 || ticks !== '0) begin n_bad++; $display("FAIL late_clear: got halted %b ticks %0d, required 0 and 0", halted, ticks); end
  endtask

  initial begin
    test_reset();
    test_manual_step();
    test_bounce();
    test_auto();
    test_reset_mid_run();
    test_simultaneous();
    test_budget();
    test_budget_late_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
